game_sequencer: RTL and testbench

Initiator side of the game plate's opcode interface: turns player key pulses and a gravity timer into a legal `opcode_e` stream for the plate. It runs the `eFetch` → done → `yumi` handshake, sequences lock-down (`eCommit`, `eCheck`, `eNew`), accumulates score from line-elimination reports, and stops issuing once the plate reports a loss. It sits between the input debouncer and the game plate; the plate's `ready_o`, `done_o`, `lose_o`, `block_cannot_move_down_o` and line-elimination outputs feed back into it.

---
 rtl/game_sequencer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_game_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : game_sequencer (with game_sequencer_pkg)
// Brief    : Opcode initiator for the game plate: key/gravity arbitration,
//            lock-down sequencing and score keeping. Optional hard drop is
//            enabled by defining GAME_SEQUENCER_HARD_DROP_EN.
// Revision : 1.0 - initial release
// =============================================================================

package game_sequencer_pkg;
    typedef enum logic [3:0] {
        eNop       = 4'd0,
        eNew       = 4'd1,
        eMoveLeft  = 4'd2,
        eMoveRight = 4'd3,
        eMoveDown  = 4'd4,
        eRotate    = 4'd5,
        eCommit    = 4'd6,
        eCheck     = 4'd7
    } opcode_e;
endpackage

module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int gravity_period_p = 1024,
    parameter int cnt_width_p      = $clog2(gravity_period_p)
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic        key_left_i,
    input  logic        key_right_i,
    input  logic        key_rotate_i,
    input  logic        key_drop_i,
    output opcode_e     opcode_o,
    output logic        opcode_v_o,
    input  logic        ready_i,
    input  logic        done_i,
    output logic        yumi_o,
    input  logic        block_cannot_move_down_i,
    input  logic        lose_i,
    input  logic [2:0]  line_elim_i,
    input  logic        line_elim_v_i,
    output logic [15:0] score_o,
    output logic [9:0]  lines_o,
    output logic        game_over_o,
    output logic        busy_o
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SELECT = 3'd1;
    localparam logic [2:0] c_ST_ISSUE  = 3'd2;
    localparam logic [2:0] c_ST_WAIT   = 3'd3;
    localparam logic [2:0] c_ST_OVER   = 3'd4;

    localparam logic [cnt_width_p-1:0] c_GRAV_LAST = cnt_width_p'(gravity_period_p - 1);
    localparam logic [cnt_width_p-1:0] c_GRAV_ONE  = cnt_width_p'(1);

    logic [2:0]             state_q, state_d;
    opcode_e                opcode_q, opcode_d;
    opcode_e                forced_q, forced_d;
    logic                   opcode_v_q, opcode_v_d;
    logic                   busy_q, busy_d;
    logic                   game_over_q, game_over_d;
    logic                   rule3_q, rule3_d;
    logic                   rot_pend_q, rot_pend_d;
    logic                   left_pend_q, left_pend_d;
    logic                   right_pend_q, right_pend_d;
    logic                   grav_pend_q, grav_pend_d;
    logic                   drop_mode_q, drop_mode_d;
    logic [cnt_width_p-1:0] grav_cnt_q, grav_cnt_d;
    logic [15:0]            score_q, score_d;
    logic [9:0]             lines_q, lines_d;

    logic                   w_active;
    logic                   w_start;
    logic                   w_xfer;
    logic                   w_grav_tick;
    logic                   w_sel_v;
    logic                   w_sel_rule3;
    opcode_e                w_sel_op;
    logic [15:0]            w_score_add;
    logic [16:0]            w_score_sum;
    logic [10:0]            w_lines_sum;

    assign w_active    = (state_q == c_ST_SELECT) || (state_q == c_ST_ISSUE) ||
                         (state_q == c_ST_WAIT);
    assign w_start     = (state_q == c_ST_IDLE) && start_i;
    assign w_xfer      = (state_q == c_ST_ISSUE) && ready_i;
    assign w_grav_tick = w_active && (grav_cnt_q == c_GRAV_LAST);

    // Arbitration among pending requests; forced lock-down steps win.
    always_comb begin
        w_sel_v     = 1'b1;
        w_sel_rule3 = 1'b0;
        w_sel_op    = eNop;
        if (forced_q != eNop) begin
            w_sel_op = forced_q;
        end else if (drop_mode_q || grav_pend_q) begin
            w_sel_rule3 = 1'b1;
            w_sel_op    = block_cannot_move_down_i ? eCommit : eMoveDown;
        end else if (rot_pend_q) begin
            w_sel_op = eRotate;
        end else if (left_pend_q) begin
            w_sel_op = eMoveLeft;
        end else if (right_pend_q) begin
            w_sel_op = eMoveRight;
        end else begin
            w_sel_v = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (start_i) state_d = c_ST_ISSUE;
            end
            c_ST_SELECT: begin
                if (lose_i)       state_d = c_ST_OVER;
                else if (w_sel_v) state_d = c_ST_ISSUE;
            end
            c_ST_ISSUE: begin
                if (ready_i) state_d = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (done_i) state_d = c_ST_SELECT;
            end
            c_ST_OVER: state_d = c_ST_OVER;
            default:   state_d = c_ST_IDLE;
        endcase
    end

    // opcode_q keeps the transferred opcode through WAIT so the lock-down
    // successor can be derived when done arrives.
    always_comb begin
        opcode_d = opcode_q;
        rule3_d  = rule3_q;
        if (w_start) begin
            opcode_d = eNew;
            rule3_d  = 1'b0;
        end else if ((state_q == c_ST_SELECT) && !lose_i && w_sel_v) begin
            opcode_d = w_sel_op;
            rule3_d  = w_sel_rule3;
        end
        opcode_v_d  = (state_d == c_ST_ISSUE);
        busy_d      = (state_d == c_ST_ISSUE) || (state_d == c_ST_WAIT);
        game_over_d = (state_d == c_ST_OVER);
    end

    assign yumi_o = (state_q == c_ST_WAIT) && done_i;

    always_comb begin
        forced_d = forced_q;
        if (w_start) begin
            forced_d = eNop;
        end else if ((state_q == c_ST_WAIT) && done_i) begin
            case (opcode_q)
                eCommit: forced_d = eCheck;
                eCheck:  forced_d = eNew;
                default: forced_d = eNop;
            endcase
        end
    end

    // Clears happen first so a press landing on its own transfer stays queued.
    always_comb begin
        rot_pend_d   = rot_pend_q;
        left_pend_d  = left_pend_q;
        right_pend_d = right_pend_q;
        grav_pend_d  = grav_pend_q;
        drop_mode_d  = drop_mode_q;
        if (w_start) begin
            rot_pend_d   = 1'b0;
            left_pend_d  = 1'b0;
            right_pend_d = 1'b0;
            grav_pend_d  = 1'b0;
            drop_mode_d  = 1'b0;
        end else begin
            if (w_xfer && (opcode_q == eRotate))    rot_pend_d   = 1'b0;
            if (w_xfer && (opcode_q == eMoveLeft))  left_pend_d  = 1'b0;
            if (w_xfer && (opcode_q == eMoveRight)) right_pend_d = 1'b0;
            if (w_xfer && rule3_q)                  grav_pend_d  = 1'b0;
            if (w_xfer && rule3_q && (opcode_q == eCommit)) drop_mode_d = 1'b0;
            if (w_active && key_rotate_i) rot_pend_d   = 1'b1;
            if (w_active && key_left_i)   left_pend_d  = 1'b1;
            if (w_active && key_right_i)  right_pend_d = 1'b1;
            if (w_grav_tick)              grav_pend_d  = 1'b1;
`ifdef GAME_SEQUENCER_HARD_DROP_EN
            if (w_active && key_drop_i)   drop_mode_d  = 1'b1;
`else
            drop_mode_d = 1'b0;
`endif
        end
    end

`ifndef GAME_SEQUENCER_HARD_DROP_EN
    logic unused_key_drop;
    assign unused_key_drop = key_drop_i;
`endif

    always_comb begin
        if (!w_active)        grav_cnt_d = '0;
        else if (w_grav_tick) grav_cnt_d = '0;
        else                  grav_cnt_d = grav_cnt_q + c_GRAV_ONE;
    end

    always_comb begin
        case (line_elim_i)
            3'd0:    w_score_add = 16'd0;
            3'd1:    w_score_add = 16'd100;
            3'd2:    w_score_add = 16'd300;
            3'd3:    w_score_add = 16'd500;
            default: w_score_add = 16'd800;
        endcase
        w_score_sum = {1'b0, score_q} + {1'b0, w_score_add};
        w_lines_sum = {1'b0, lines_q} + {8'd0, line_elim_i};
        score_d     = score_q;
        lines_d     = lines_q;
        if (w_start) begin
            score_d = '0;
            lines_d = '0;
        end else if (line_elim_v_i) begin
            score_d = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
            lines_d = w_lines_sum[10] ? 10'd1023 : w_lines_sum[9:0];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            opcode_q     <= eNop;
            forced_q     <= eNop;
            opcode_v_q   <= 1'b0;
            busy_q       <= 1'b0;
            game_over_q  <= 1'b0;
            rule3_q      <= 1'b0;
            rot_pend_q   <= 1'b0;
            left_pend_q  <= 1'b0;
            right_pend_q <= 1'b0;
            grav_pend_q  <= 1'b0;
            drop_mode_q  <= 1'b0;
            grav_cnt_q   <= '0;
            score_q      <= '0;
            lines_q      <= '0;
        end else begin
            opcode_q     <= opcode_d;
            forced_q     <= forced_d;
            opcode_v_q   <= opcode_v_d;
            busy_q       <= busy_d;
            game_over_q  <= game_over_d;
            rule3_q      <= rule3_d;
            rot_pend_q   <= rot_pend_d;
            left_pend_q  <= left_pend_d;
            right_pend_q <= right_pend_d;
            grav_pend_q  <= grav_pend_d;
            drop_mode_q  <= drop_mode_d;
            grav_cnt_q   <= grav_cnt_d;
            score_q      <= score_d;
            lines_q      <= lines_d;
        end
    end

    assign opcode_o    = opcode_q;
    assign opcode_v_o  = opcode_v_q;
    assign busy_o      = busy_q;
    assign game_over_o = game_over_q;
    assign score_o     = score_q;
    assign lines_o     = lines_q;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_game_sequencer
// Brief    : Randomized scoreboard bench for game_sequencer; a request-list
//            model predicts opcodes, handshake outputs and score.
// Revision : 1.0 - initial release
// =============================================================================
module tb_game_sequencer;
    import game_sequencer_pkg::*;

    localparam int P       = 16;
    localparam int PH_IDLE = 0;
    localparam int PH_SEL  = 1;
    localparam int PH_ISS  = 2;
    localparam int PH_WT   = 3;
    localparam int PH_OVER = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start_i, key_left_i, key_right_i, key_rotate_i, key_drop_i;
    logic        ready_i, done_i, bcmd_i, lose_i, line_elim_v_i;
    logic [2:0]  line_elim_i;
    opcode_e     opcode_o;
    logic        opcode_v_o, yumi_o, game_over_o, busy_o;
    logic [15:0] score_o;
    logic [9:0]  lines_o;

    game_sequencer #(.gravity_period_p(P)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start_i),
        .key_left_i(key_left_i), .key_right_i(key_right_i),
        .key_rotate_i(key_rotate_i), .key_drop_i(key_drop_i),
        .opcode_o(opcode_o), .opcode_v_o(opcode_v_o), .ready_i(ready_i),
        .done_i(done_i), .yumi_o(yumi_o), .block_cannot_move_down_i(bcmd_i),
        .lose_i(lose_i), .line_elim_i(line_elim_i), .line_elim_v_i(line_elim_v_i),
        .score_o(score_o), .lines_o(lines_o), .game_over_o(game_over_o), .busy_o(busy_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int hold_ready = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state: phase of the game, the set of outstanding requests.
    int      m_phase, m_cnt, m_score, m_lines;
    bit      m_rot, m_left, m_right, m_grav, m_drop, m_r3;
    opcode_e m_cur, m_forced;
    opcode_e exp_q[$];
    int      sc_q[$];
    int      ln_q[$];

    function automatic int score_of(input int n);
        case (n)
            0: return 0;
            1: return 100;
            2: return 300;
            3: return 500;
            default: return 800;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_cnt = 0; m_score = 0; m_lines = 0;
        {m_rot, m_left, m_right, m_grav, m_drop, m_r3} = '0;
        m_cur = eNop; m_forced = eNop;
        exp_q.delete(); sc_q.delete(); ln_q.delete();
    endtask

    initial begin : model
        int      old;
        bit      pick, r3;
        opcode_e op;
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                old = m_phase;
                if (old == PH_IDLE && start_i) begin
                    m_score = 0; m_lines = 0;
                    sc_q.push_back(0); ln_q.push_back(0);
                end else if (line_elim_v_i) begin
                    m_score = (m_score + score_of(line_elim_i) > 65535) ? 65535 : m_score + score_of(line_elim_i);
                    m_lines = (m_lines + line_elim_i > 1023) ? 1023 : m_lines + line_elim_i;
                    sc_q.push_back(m_score); ln_q.push_back(m_lines);
                end
                case (old)
                    PH_IDLE: if (start_i) begin
                        m_phase = PH_ISS; m_cnt = 0; m_forced = eNop;
                        {m_rot, m_left, m_right, m_grav, m_drop} = '0;
                        m_cur = eNew; m_r3 = 0; exp_q.push_back(eNew);
                    end
                    PH_SEL: if (lose_i) begin
                        m_phase = PH_OVER;
                    end else begin
                        pick = 1; r3 = 0; op = eNop;
                        if (m_forced != eNop)      op = m_forced;
                        else if (m_drop || m_grav) begin r3 = 1; op = bcmd_i ? eCommit : eMoveDown; end
                        else if (m_rot)            op = eRotate;
                        else if (m_left)           op = eMoveLeft;
                        else if (m_right)          op = eMoveRight;
                        else                       pick = 0;
                        if (pick) begin
                            m_phase = PH_ISS; m_cur = op; m_r3 = r3; exp_q.push_back(op);
                        end
                    end
                    PH_ISS: if (ready_i) begin
                        m_phase = PH_WT;
                        if (m_cur == eRotate)    m_rot   = 0;
                        if (m_cur == eMoveLeft)  m_left  = 0;
                        if (m_cur == eMoveRight) m_right = 0;
                        if (m_r3) begin
                            m_grav = 0;
                            if (m_cur == eCommit) m_drop = 0;
                        end
                    end
                    PH_WT: if (done_i) begin
                        m_phase  = PH_SEL;
                        m_forced = (m_cur == eCommit) ? eCheck : (m_cur == eCheck) ? eNew : eNop;
                    end
                    default: ;
                endcase
                if (old == PH_SEL || old == PH_ISS || old == PH_WT) begin
                    if (key_rotate_i) m_rot   = 1;
                    if (key_left_i)   m_left  = 1;
                    if (key_right_i)  m_right = 1;
`ifdef GAME_SEQUENCER_HARD_DROP_EN
                    if (key_drop_i)   m_drop  = 1;
`endif
                    if (m_cnt == P - 1) begin m_cnt = 0; m_grav = 1; end
                    else m_cnt++;
                end
            end
        end
    end

    initial begin : monitor
        logic    pv, pr;
        opcode_e pop;
        pv = 0; pr = 0; pop = eNop;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pv = 0;
            end else begin
                chk("opcode_v", int'(opcode_v_o), int'(m_phase == PH_ISS));
                chk("busy", int'(busy_o), int'(m_phase == PH_ISS || m_phase == PH_WT));
                chk("yumi", int'(yumi_o), int'(m_phase == PH_WT && done_i));
                chk("game_over", int'(game_over_o), int'(m_phase == PH_OVER));
                if (opcode_v_o && pv && !pr) chk("opcode_stable", int'(opcode_o), int'(pop));
                if (opcode_v_o && ready_i) begin
                    chk("xfer_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) chk("opcode", int'(opcode_o), int'(exp_q.pop_front()));
                end
                if (sc_q.size() > 0) begin
                    chk("score", int'(score_o), sc_q.pop_front());
                    chk("lines", int'(lines_o), ln_q.pop_front());
                end
                pv = opcode_v_o; pr = ready_i; pop = opcode_o;
            end
        end
    end

    // Plate model: random fetch readiness, done 0..3 cycles after transfer.
    initial begin : plate
        bit xf;
        int dcnt;
        dcnt = -1;
        forever begin
            @(negedge clk);
            xf = opcode_v_o && ready_i && reset_n;
            @(posedge clk);
            #1;
            done_i = 1'b0;
            if (!reset_n) begin
                dcnt = -1; ready_i = 1'b0;
            end else begin
                if (xf) dcnt = $urandom_range(0, 3);
                if (dcnt == 0) begin done_i = 1'b1; dcnt = -1; end
                else if (dcnt > 0) dcnt--;
                ready_i = (hold_ready > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
                if (hold_ready > 0) hold_ready--;
            end
        end
    end

    task automatic clear_stim();
        {start_i, key_left_i, key_right_i, key_rotate_i, key_drop_i} = '0;
        {bcmd_i, line_elim_v_i} = '0;
        line_elim_i = 3'd0;
    endtask

    task automatic run_random(input int ncyc, input int keys_on);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            key_left_i    = keys_on != 0 && $urandom_range(0, 11) == 0;
            key_right_i   = keys_on != 0 && $urandom_range(0, 11) == 0;
            key_rotate_i  = keys_on != 0 && $urandom_range(0, 11) == 0;
            key_drop_i    = keys_on != 0 && $urandom_range(0, 11) == 0;
            bcmd_i        = $urandom_range(0, 3) == 0;
            line_elim_v_i = keys_on != 0 && $urandom_range(0, 19) == 0;
            line_elim_i   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) hold_ready = 5;
        end
        @(posedge clk); #1;
        clear_stim();
    endtask

    task automatic start_game();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_opcode"}, int'(opcode_o), int'(eNop));
        chk({tag, "_opcode_v"}, int'(opcode_v_o), 0);
        chk({tag, "_yumi"}, int'(yumi_o), 0);
        chk({tag, "_score"}, int'(score_o), 0);
        chk({tag, "_lines"}, int'(lines_o), 0);
        chk({tag, "_game_over"}, int'(game_over_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit found;
        reset_n = 1'b0; lose_i = 1'b0; ready_i = 1'b0; done_i = 1'b0;
        clear_stim();
        #1 chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        @(posedge clk); #1 line_elim_v_i = 1'b1; line_elim_i = 3'd4;
        @(posedge clk); #1 line_elim_i = 3'd1;
        @(posedge clk); #1 line_elim_v_i = 1'b0;
        @(negedge clk);
        chk("score_900", int'(score_o), 900);
        chk("lines_5", int'(lines_o), 5);

        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1 line_elim_v_i = 1'b1; line_elim_i = 3'($urandom_range(4, 7));
        end
        @(posedge clk); #1 line_elim_v_i = 1'b0;
        @(negedge clk);
        chk("score_sat", int'(score_o), 16'hFFFF);
        chk("lines_sat", int'(lines_o), 1023);

        start_game();
        run_random(120, 0);
        run_random(3000, 1);

        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            found = busy_o && !opcode_v_o;
        end
        chk("wait_state_found", int'(found), 1);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(posedge clk); #1 reset_n = 1'b1;

        start_game();
        run_random(1000, 1);

        lose_i = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            found = game_over_o;
        end
        chk("game_over_reached", int'(found), 1);
        run_random(60, 1);
        @(negedge clk);
        chk("over_no_opcode", int'(opcode_v_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
